// File: rtl/swap_sort_controller.sv
// swap_sort_controller: command-side master that bubble-sorts an 8-entry
// register file by issuing x/y/swap commands and watching r[7:0].
module swap_sort_controller #(
    parameter int WIDTH      = 4,
    parameter bit DESCENDING = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] r [7:0],
    output logic [2:0]       x,
    output logic [2:0]       y,
    output logic             swap,
    output logic             busy,
    output logic             done,
    output logic [4:0]       swap_count,
    output logic [2:0]       pass_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        SWP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] j;
    logic [2:0] j_next;
    logic [2:0] limit;
    logic [2:0] limit_next;
    logic       swapped;
    logic       swapped_next;
    logic [4:0] swap_count_next;
    logic [2:0] pass_count_next;
    logic [2:0] j_plus;
    logic       need;

    assign j_plus = 3'(j + 3'd1);

    // Compare the current neighbour pair; equal values never need a swap.
    always_comb begin
        if (DESCENDING) begin
            need = (r[j] < r[j_plus]);
        end else begin
            need = (r[j] > r[j_plus]);
        end
    end

    // Next-state logic: walk j across the pass, shrink limit at each pass end.
    always_comb begin
        state_next      = state;
        j_next          = j;
        limit_next      = limit;
        swapped_next    = swapped;
        swap_count_next = swap_count;
        pass_count_next = pass_count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next      = CMP;
                    j_next          = 3'd0;
                    limit_next      = 3'd6;
                    swapped_next    = 1'b0;
                    swap_count_next = 5'd0;
                    pass_count_next = 3'd1;
                end
            end
            CMP: begin
                if (need) begin
                    state_next = SWP;
                end else if (j < limit) begin
                    j_next = j_plus;
                end else if (!swapped || limit == 3'd0) begin
                    state_next = DONE;
                end else begin
                    j_next          = 3'd0;
                    limit_next      = 3'(limit - 3'd1);
                    swapped_next    = 1'b0;
                    pass_count_next = 3'(pass_count + 3'd1);
                end
            end
            SWP: begin
                swapped_next    = 1'b1;
                swap_count_next = 5'(swap_count + 5'd1);
                if (j < limit) begin
                    state_next = CMP;
                    j_next     = j_plus;
                end else if (limit == 3'd0) begin
                    state_next = DONE;
                end else begin
                    state_next      = CMP;
                    j_next          = 3'd0;
                    limit_next      = 3'(limit - 3'd1);
                    swapped_next    = 1'b0;
                    pass_count_next = 3'(pass_count + 3'd1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and sort bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            j          <= 3'd0;
            limit      <= 3'd6;
            swapped    <= 1'b0;
            swap_count <= 5'd0;
            pass_count <= 3'd0;
        end else begin
            state      <= state_next;
            j          <= j_next;
            limit      <= limit_next;
            swapped    <= swapped_next;
            swap_count <= swap_count_next;
            pass_count <= pass_count_next;
        end
    end

    // Moore outputs decoded from the registered state and pair index.
    always_comb begin
        busy = (state == CMP) || (state == SWP);
        swap = (state == SWP);
        done = (state == DONE);
        x    = busy ? j : 3'd0;
        y    = 3'(x + 3'd1);
    end

endmodule

// File: tb/tb_swap_sort_controller.sv
// tb_swap_sort_controller: drives two controllers (ascending and descending)
// against bench-owned register file models and checks against a bubble-sort model.
module tb_swap_sort_controller;

    logic       clk;
    logic       reset;
    logic       start_a;
    logic       start_d;
    logic [3:0] regs_a [7:0];
    logic [3:0] regs_d [7:0];
    logic [2:0] x_a, y_a, x_d, y_d;
    logic       swap_a, busy_a, done_a, swap_d, busy_d, done_d;
    logic [4:0] swap_count_a, swap_count_d;
    logic [2:0] pass_count_a, pass_count_d;

    int checks;
    int errors;
    bit sel;

    logic [2:0] obs_x, obs_y, obs_pass;
    logic       obs_swap, obs_busy, obs_done;
    logic [4:0] obs_swaps;

    assign obs_x     = sel ? x_d : x_a;
    assign obs_y     = sel ? y_d : y_a;
    assign obs_swap  = sel ? swap_d : swap_a;
    assign obs_busy  = sel ? busy_d : busy_a;
    assign obs_done  = sel ? done_d : done_a;
    assign obs_swaps = sel ? swap_count_d : swap_count_a;
    assign obs_pass  = sel ? pass_count_d : pass_count_a;

    swap_sort_controller #(.WIDTH(4), .DESCENDING(1'b0)) dut_asc (
        .clk(clk), .reset(reset), .start(start_a), .r(regs_a),
        .x(x_a), .y(y_a), .swap(swap_a), .busy(busy_a), .done(done_a),
        .swap_count(swap_count_a), .pass_count(pass_count_a)
    );

    swap_sort_controller #(.WIDTH(4), .DESCENDING(1'b1)) dut_desc (
        .clk(clk), .reset(reset), .start(start_d), .r(regs_d),
        .x(x_d), .y(y_d), .swap(swap_d), .busy(busy_d), .done(done_d),
        .swap_count(swap_count_d), .pass_count(pass_count_d)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file models: exchange the addressed pair on a swap command.
    always @(posedge clk) begin
        if (swap_a) begin
            regs_a[x_a] <= regs_a[y_a];
            regs_a[y_a] <= regs_a[x_a];
        end
        if (swap_d) begin
            regs_d[x_d] <= regs_d[y_d];
            regs_d[y_d] <= regs_d[x_d];
        end
    end

    function automatic logic [31:0] pack(input logic [3:0] a [7:0]);
        return {a[7], a[6], a[5], a[4], a[3], a[2], a[1], a[0]};
    endfunction

    // Reference: plain bubble sort with early exit, plus an independent inversion count.
    task automatic modelSort(input logic [3:0] in_v [7:0], input bit desc,
                             output logic [31:0] sorted, output int n_cmp,
                             output int n_swp, output int n_pass, output int n_inv);
        logic [3:0] a [7:0];
        logic [3:0] t;
        bit any;
        a = in_v;
        n_cmp = 0; n_swp = 0; n_pass = 0; n_inv = 0;
        for (int i = 0; i < 8; i++)
            for (int k = i + 1; k < 8; k++)
                if (desc ? (a[i] < a[k]) : (a[i] > a[k])) n_inv++;
        for (int lim = 6; lim >= 0; lim--) begin
            any = 1'b0;
            n_pass++;
            for (int k = 0; k <= lim; k++) begin
                n_cmp++;
                if (desc ? (a[k] < a[k+1]) : (a[k] > a[k+1])) begin
                    t = a[k]; a[k] = a[k+1]; a[k+1] = t;
                    any = 1'b1;
                    n_swp++;
                end
            end
            if (!any) break;
        end
        sorted = pack(a);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_x"}, 32'(obs_x), 32'd0);
        checkOutput({tag, "_y"}, 32'(obs_y), 32'd1);
        checkOutput({tag, "_swap"}, 32'(obs_swap), 32'd0);
        checkOutput({tag, "_busy"}, 32'(obs_busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(obs_done), 32'd0);
        checkOutput({tag, "_swap_count"}, 32'(obs_swaps), 32'd0);
        checkOutput({tag, "_pass_count"}, 32'(obs_pass), 32'd0);
    endtask

    // Load a register file, pulse start, follow the sort and compare with the model.
    // poke_at: busy cycle for a stray start pulse (0 = none).
    // abort_at: busy cycle on which reset is asserted (0 = run to completion).
    task automatic applyStimulus(input bit s, input logic [3:0] vals [7:0],
                                 input int poke_at, input int abort_at);
        logic [31:0] exp_sorted;
        int n_cmp, n_swp, n_pass, n_inv;
        int busy_cyc, swp_cyc, xy_bad, done_early, cyc;
        modelSort(vals, s, exp_sorted, n_cmp, n_swp, n_pass, n_inv);
        @(negedge clk);
        sel = s;
        if (s) begin regs_d = vals; start_d = 1'b1; end
        else begin regs_a = vals; start_a = 1'b1; end
        @(negedge clk);
        start_a = 1'b0; start_d = 1'b0;
        busy_cyc = 0; swp_cyc = 0; xy_bad = 0; done_early = 0; cyc = 0;
        while (obs_busy && cyc < 200) begin
            busy_cyc++;
            if (obs_swap) swp_cyc++;
            if (obs_done) done_early++;
            if (obs_x > 3'd6 || obs_y != 3'(obs_x + 3'd1)) xy_bad++;
            if (abort_at != 0 && busy_cyc == abort_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                checkIdleOutputs("abort");
                return;
            end
            start_a = (poke_at != 0 && busy_cyc == poke_at && !s);
            start_d = (poke_at != 0 && busy_cyc == poke_at && s);
            @(negedge clk);
            start_a = 1'b0; start_d = 1'b0;
            cyc++;
        end
        checkOutput("busy_cycles", 32'(busy_cyc), 32'(n_cmp + n_swp));
        checkOutput("swap_cycles", 32'(swp_cyc), 32'(n_swp));
        checkOutput("swap_equals_inversions", 32'(swp_cyc), 32'(n_inv));
        checkOutput("xy_pairs_bad", 32'(xy_bad), 32'd0);
        checkOutput("done_while_busy", 32'(done_early), 32'd0);
        checkOutput("done_pulse", 32'(obs_done), 32'd1);
        checkOutput("swap_count", 32'(obs_swaps), 32'(n_swp));
        checkOutput("pass_count", 32'(obs_pass), 32'(n_pass));
        checkOutput("final_r", s ? pack(regs_d) : pack(regs_a), exp_sorted);
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(obs_done), 32'd0);
        checkOutput("counts_hold", 32'({obs_swaps, obs_pass}), 32'({5'(n_swp), 3'(n_pass)}));
    endtask

    // Directed scenarios followed by randomized arrays on both sort orders.
    initial begin
        logic [3:0] v [7:0];
        logic [3:0] cur [7:0];
        checks = 0; errors = 0; sel = 1'b0;
        start_a = 1'b0; start_d = 1'b0;
        for (int i = 0; i < 8; i++) begin regs_a[i] = 4'(i); regs_d[i] = 4'(i); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkIdleOutputs("reset");

        $display("[TB] ascending input, ascending order");
        for (int i = 0; i < 8; i++) v[i] = 4'(i);
        applyStimulus(1'b0, v, 0, 0);

        $display("[TB] reversed input, ascending order");
        for (int i = 0; i < 8; i++) v[i] = 4'(7 - i);
        applyStimulus(1'b0, v, 0, 0);

        $display("[TB] equal neighbours");
        v[0] = 4'd3; v[1] = 4'd3; v[2] = 4'd1; v[3] = 4'd3;
        v[4] = 4'd0; v[5] = 4'd3; v[6] = 4'd3; v[7] = 4'd3;
        applyStimulus(1'b0, v, 0, 0);

        $display("[TB] ascending input, descending order");
        for (int i = 0; i < 8; i++) v[i] = 4'(i);
        applyStimulus(1'b1, v, 0, 0);

        $display("[TB] reset on 10th busy cycle, then resort with stray start");
        for (int i = 0; i < 8; i++) v[i] = 4'(7 - i);
        applyStimulus(1'b0, v, 0, 10);
        cur = regs_a;
        applyStimulus(1'b0, cur, 5, 0);

        $display("[TB] randomized arrays");
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 8; i++) v[i] = 4'($urandom_range(0, 15));
            applyStimulus(t[0], v, (t > 3) ? 3 : 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
